// File: rtl/cnt_pkg.sv
// Shared definitions for the counter primitives and the shared-timer arbiter.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package cnt_pkg;

    // Arbiter/timer state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter direction selects used by the counter primitives
    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

    // Width of an index into n requesters (at least one bit)
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/timer_arb_rr_pick.sv
// Round-robin winner select: first set req bit after index 'last', wrapping.
// Latency: combinational.
// Backpressure: none; valid is low when no request is pending.
module rr_pick
    import cnt_pkg::*;
#(
    parameter int nreq = 4,
    localparam int IW  = idx_w(nreq)
) (
    input  logic [nreq-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            valid,
    output logic [IW-1:0]   winner
);

    logic [IW-1:0] pos;

    // Scan from the farthest offset down so the nearest set bit after 'last' wins
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        pos    = '0;
        for (int k = nreq; k >= 1; k--) begin
            pos = IW'((int'(last) + k) % nreq);
            if (req[pos]) begin
                valid  = 1'b1;
                winner = pos;
            end
        end
    end

endmodule

// File: rtl/timer_arb.sv
// One down-counting delay timer shared round-robin among nreq requesters.
// Latency: grant one edge after request seen in IDLE; gnt lasts top+1 cycles, done pulses right after.
// Backpressure: requests are level-held; losers wait, dropping the owner's req aborts without done.
module timer_arb
    import cnt_pkg::*;
#(
    parameter int width = 8,
    parameter int nreq  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [nreq-1:0]       req,
    input  logic [nreq*width-1:0] top,
    output logic [nreq-1:0]       gnt,
    output logic [nreq-1:0]       done,
    output logic                  busy,
    output logic [width-1:0]      cnt
);

    localparam int            IW       = idx_w(nreq);
    localparam logic [IW-1:0] LAST_RST = IW'(nreq - 1);

    state_t           state_q;
    logic [nreq-1:0]  gnt_q;
    logic [nreq-1:0]  done_q;
    logic [width-1:0] cnt_q;
    logic [IW-1:0]    last_q;
    logic [IW-1:0]    owner_q;

    logic             pick_vld;
    logic [IW-1:0]    pick_win;
    logic [width-1:0] top_win;

    function automatic logic [nreq-1:0] onehot(input logic [IW-1:0] idx);
        logic [nreq-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    rr_pick #(
        .nreq   (nreq)
    ) u_pick (
        .req    (req),
        .last   (last_q),
        .valid  (pick_vld),
        .winner (pick_win)
    );

    // Mux out the winner's delay so it can be captured at the grant edge
    always_comb begin
        top_win = '0;
        for (int i = 0; i < nreq; i++) begin
            if (pick_win == IW'(i)) begin
                top_win = top[i*width +: width];
            end
        end
    end

    // Arbitration FSM, counter and registered grant/done outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            owner_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= '0;
                    if (pick_vld) begin
                        gnt_q   <= onehot(pick_win);
                        cnt_q   <= top_win;
                        last_q  <= pick_win;
                        owner_q <= pick_win;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Abort outranks expiry: a dropped request never sees done
                    if (!req[owner_q]) begin
                        gnt_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == '0) begin
                        gnt_q   <= '0;
                        done_q  <= onehot(owner_q);
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    // Bubble cycle lets the requester drop req before re-arbitration
                    done_q  <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt_q   <= '0;
                    done_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign cnt  = cnt_q;
    assign busy = (state_q != ST_IDLE);

endmodule

// File: doc/timer_arb.md
Name: timer_arb

Overview:
- Shares one down-counting delay timer among `nreq` requesters.
- Each requester asks for a delay of `top` ticks. A round-robin arbiter grants the timer to one requester at a time.
- The grantee's `top` is loaded into the counter, which runs to zero and then returns a one-cycle done pulse to that requester.
- Sits between the counter primitives and client blocks that need programmable timeouts, so no client needs a private counter.

Parameters:
- width, 8, bit width of each top value and of the counter.
- nreq, 4, number of requesters (2..8).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- req  input  nreq  level request per requester; held high until done seen.
- top  input  nreq*width  packed delay values; slice i = top[i*width +: width].
- gnt  output  nreq  one-hot grant, registered; high while requester owns the timer.
- done  output  nreq  one-hot, one-cycle pulse, registered; delay expired for that requester.
- busy  output  1  high whenever the state is not IDLE.
- cnt  output  width  current counter value (debug/observe).

Behaviour:
- Reset (async, rst=1): state=IDLE, gnt=0, done=0, cnt=0, busy=0, rr pointer last=nreq-1 (so requester 0 wins first).
- States:
  - IDLE: if any req bit is high, pick winner w = first set bit searching last+1, last+2, ... (mod nreq).
    - At the edge: gnt<=onehot(w), cnt<=top[w] (captured; later top changes ignored), last<=w, owner<=w, state<=RUN.
    - If no req: stay IDLE.
  - RUN:
    - If req[owner]=0 (abort): gnt<=0, cnt<=0, state<=IDLE, no done.
    - Else if cnt==0: gnt<=0, done<=onehot(owner), state<=DONE.
    - Else: cnt<=cnt-1 (no wrap; the 0 check takes priority).
  - DONE: done<=0, state<=IDLE unconditionally (one bubble cycle).
- Latency: gnt is high for exactly top+1 cycles and done pulses in the cycle immediately after gnt falls. top=0 gives a 1-cycle gnt, then done.
- Requester protocol:
  - On seeing done=1, the requester deasserts req at the next edge. It is therefore low in the following IDLE cycle.
  - If req is still high in IDLE, it is a new request. It is arbitrated normally and has lowest priority due to the rr pointer.
- Simultaneous events:
  - The abort check has priority over expiry in RUN. If req[owner] drops in the same cycle cnt==0, there is no done.
  - Non-owner req changes during RUN/DONE have no effect until IDLE.
- Width: cnt is exactly width bits. top=all-ones gives 2^width cycles of gnt.
- rst mid-RUN forces the reset values immediately. No done is emitted and the pointer returns to nreq-1.
- Invariants: at most one bit of gnt and at most one bit of done is set, and gnt and done are never high in the same cycle.

Decomposition:
- Shared package cnt_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the existing CNT_UP/CNT_DOWN direction constants.
- One sub-module is natural: rr_pick. It is combinational: inputs req[nreq] and last index, outputs valid and winner index (clog2 width).
- The FSM, counter and output registers stay in timer_arb.

Test Plan:
- Reset: hold rst=1 for 3 cycles with req=4'b1111 -> gnt=0, done=0, busy=0, cnt=0 throughout; after release, first gnt=4'b0001.
- Single request: req[0]=1, top[0]=3 at cycle 0 -> gnt=0001 cycles 1-4 with cnt 3,2,1,0; done=0001 cycle 5; busy low cycle 6.
- Contention: req=1111 all tops=1, each requester drops req after its done -> grant order 0,1,2,3; each gnt lasts 2 cycles; each done is followed by 1 bubble.
- Fairness: req[0] and req[2] held permanently (re-request immediately), tops=0 -> grants alternate 0,2,0,2; requester 0 never wins twice in a row.
- Abort: req[1]=1, top[1]=10, drop req[1] when cnt=6 -> gnt falls next edge, done stays 0, state IDLE, next pending req served.
- Reset mid-run: top[3]=5, assert rst when cnt=2 -> gnt, cnt and done clear immediately; after release with req=1111, requester 0 wins.
